// File: rtl/seq_detect_pkg.sv
// Shared types and defaults for the time-shared pattern detector.
// Histories are stored at the maximum supported width so that one context
// type serves every PAT_W; only the low PAT_W-1 history bits are meaningful.
package seq_detect_pkg;

  localparam int PAT_W_DEF = 3;
  localparam logic [PAT_W_DEF-1:0] PATTERN_DEF = 3'b101;

  localparam int PAT_W_MAX = 8;
  localparam int HIST_W    = PAT_W_MAX - 1;
  localparam int FILL_W    = 3;

  typedef struct packed {
    logic [HIST_W-1:0] hist;
    logic [FILL_W-1:0] fill;
  } ch_ctx_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_detect_step.sv
// Next-context and match logic for one accepted bit. A single instance is
// shared by all channels through the grant mux in the top level.
module seq_detect_step
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(PATTERN_DEF)
) (
  input  ch_ctx_t ctx,
  input  logic    b,
  output ch_ctx_t ctx_nxt,
  output logic    match
);

  localparam logic [FILL_W-1:0] FILL_SAT  = FILL_W'(PAT_W - 1);
  localparam logic [HIST_W-1:0] HIST_MASK = HIST_W'((1 << (PAT_W - 1)) - 1);

  logic [HIST_W:0] shifted;

  // Shift the new bit into history and compare the full window once primed.
  always_comb begin
    shifted      = {ctx.hist, b};
    ctx_nxt.hist = shifted[HIST_W-1:0] & HIST_MASK;
    ctx_nxt.fill = (ctx.fill == FILL_SAT) ? ctx.fill : ctx.fill + FILL_W'(1);
    match        = (ctx.fill == FILL_SAT) && (shifted[PAT_W-1:0] == PATTERN);
  end

endmodule

// File: rtl/seq_detect_sched.sv
// Round-robin time-shared overlapping pattern detector for NCH serial channels.
// Define SEQ_DETECT_SCHED_PRIO_EN to replace round-robin with fixed priority
// (lowest valid index wins, no rotation pointer).
module seq_detect_sched
  import seq_detect_pkg::*;
#(
  parameter int               NCH     = 4,
  parameter int               PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(PATTERN_DEF),
  parameter int               CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NCH-1:0]           ch_valid,
  input  logic [NCH-1:0]           ch_bit,
  output logic [NCH-1:0]           ch_ready,
  input  logic [NCH-1:0]           clr,
  output logic                     det_valid,
  output logic [$clog2(NCH)-1:0]   det_ch,
  input  logic [$clog2(NCH)-1:0]   rd_ch,
  output logic [CNT_W-1:0]         rd_cnt
);

  localparam int IW = idx_w(NCH);

  ch_ctx_t          ctx [NCH];
  logic [CNT_W-1:0] cnt [NCH];

  logic [IW-1:0] gnt_idx;
  logic [IW-1:0] cand;
  logic          xfer;
  ch_ctx_t       ctx_nxt;
  logic          match;
  logic          det_hit;

`ifdef SEQ_DETECT_SCHED_PRIO_EN
  // Fixed priority: scan downward so the lowest valid index is the last to win.
  always_comb begin
    gnt_idx = '0;
    cand    = '0;
    xfer    = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      cand = IW'(k);
      if (ch_valid[cand]) begin
        gnt_idx = cand;
        xfer    = 1'b1;
      end
    end
  end
`else
  logic [IW-1:0] rr_ptr;

  // Round-robin: first valid channel searching upward from rr_ptr+1.
  always_comb begin
    gnt_idx = '0;
    cand    = '0;
    xfer    = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      cand = IW'((int'(rr_ptr) + k) % NCH);
      if (!xfer && ch_valid[cand]) begin
        gnt_idx = cand;
        xfer    = 1'b1;
      end
    end
  end

  // Pointer follows the granted channel only when a transfer happens.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_ptr <= IW'(NCH - 1);
    else if (xfer) rr_ptr <= gnt_idx;
  end
`endif

  // One-hot grant; all-zero when nobody requests.
  always_comb begin
    ch_ready = '0;
    if (xfer) ch_ready[gnt_idx] = 1'b1;
  end

  seq_detect_step #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_step (
    .ctx     (ctx[gnt_idx]),
    .b       (ch_bit[gnt_idx]),
    .ctx_nxt (ctx_nxt),
    .match   (match)
  );

  // A same-cycle clear of the granted channel swallows its bit.
  assign det_hit = xfer && match && !clr[gnt_idx];

  // Per-channel history, fill and saturating match counter; clear has priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        ctx[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (clr[i]) begin
          ctx[i] <= '0;
          cnt[i] <= '0;
        end else if (xfer && gnt_idx == IW'(i)) begin
          ctx[i] <= ctx_nxt;
          if (match && cnt[i] != '1) cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Detection pulse one cycle after the matching transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      det_valid <= 1'b0;
      det_ch    <= '0;
    end else begin
      det_valid <= det_hit;
      if (det_hit) det_ch <= gnt_idx;
    end
  end

  assign rd_cnt = cnt[rd_ch];

endmodule

// File: tb/tb_seq_detect_sched.sv
// Directed self-checking bench for seq_detect_sched (NCH=4, PATTERN=101,
// CNT_W=2 so counter saturation is reachable in a few bits).
module tb_seq_detect_sched;

  logic       clk;
  logic       reset;
  logic [3:0] ch_valid;
  logic [3:0] ch_bit;
  logic [3:0] ch_ready;
  logic [3:0] clr;
  logic       det_valid;
  logic [1:0] det_ch;
  logic [1:0] rd_ch;
  logic [1:0] rd_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  seq_detect_sched #(
    .NCH     (4),
    .PAT_W   (3),
    .PATTERN (3'b101),
    .CNT_W   (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ch_valid  (ch_valid),
    .ch_bit    (ch_bit),
    .ch_ready  (ch_ready),
    .clr       (clr),
    .det_valid (det_valid),
    .det_ch    (det_ch),
    .rd_ch     (rd_ch),
    .rd_cnt    (rd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] v, input logic [3:0] b, input logic [3:0] c);
    ch_valid = v;
    ch_bit   = b;
    clr      = c;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    drive(4'b0, 4'b0, 4'b0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    drive(4'b0, 4'b0, 4'b0);
    rd_ch = 2'd0;
    reset = 1'b1;
    step();
    step();
    n_cmp++;
    if (det_valid !== 1'b0) begin n_bad++; $display("FAIL reset_det_valid got %b want 0", det_valid); end
    n_cmp++;
    if (det_ch !== 2'd0) begin n_bad++; $display("FAIL reset_det_ch got %0d want 0", det_ch); end
    for (int i = 0; i < 4; i++) begin
      rd_ch = 2'(i);
      #1;
      n_cmp++;
      if (rd_cnt !== 2'd0) begin n_bad++; $display("FAIL reset_cnt ch%0d got %0d want 0", i, rd_cnt); end
    end
    ch_valid = 4'hf;
    #1;
    n_cmp++;
    if (ch_ready !== 4'b0001) begin n_bad++; $display("FAIL reset_first_grant got %b want 0001", ch_ready); end
    ch_valid = 4'h0;
    #1;
    n_cmp++;
    if (ch_ready !== 4'b0000) begin n_bad++; $display("FAIL idle_ready got %b want 0000", ch_ready); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [4:0] seq;
    logic       exp_det;
    seq = 5'b10101;
    apply_reset();
    rd_ch = 2'd0;
    for (int k = 0; k < 5; k++) begin
      drive(4'b0001, {3'b000, seq[4-k]}, 4'b0);
      #1;
      n_cmp++;
      if (ch_ready !== 4'b0001) begin n_bad++; $display("FAIL single_ready bit%0d got %b want 0001", k, ch_ready); end
      step();
      exp_det = (k == 2) || (k == 4);
      n_cmp++;
      if (det_valid !== exp_det) begin n_bad++; $display("FAIL single_det bit%0d got %b want %b", k, det_valid, exp_det); end
      if (exp_det) begin
        n_cmp++;
        if (det_ch !== 2'd0) begin n_bad++; $display("FAIL single_det_ch bit%0d got %0d want 0", k, det_ch); end
      end
    end
    drive(4'b0, 4'b0, 4'b0);
    #1;
    n_cmp++;
    if (rd_cnt !== 2'd2) begin n_bad++; $display("FAIL single_cnt got %0d want 2", rd_cnt); end
  endtask

  task automatic test_round_robin();
    logic [2:0] seq;
    logic [3:0] exp_rdy;
    logic       b;
    seq = 3'b101;
    apply_reset();
    for (int k = 0; k < 12; k++) begin
      b = seq[2 - k/4];
      drive(4'hf, {4{b}}, 4'b0);
      exp_rdy = 4'b0001 << (k % 4);
      #1;
      n_cmp++;
      if (ch_ready !== exp_rdy) begin n_bad++; $display("FAIL rr_grant cycle%0d got %b want %b", k, ch_ready, exp_rdy); end
      step();
      n_cmp++;
      if (det_valid !== (k >= 8)) begin n_bad++; $display("FAIL rr_det cycle%0d got %b want %b", k, det_valid, (k >= 8)); end
      if (k >= 8) begin
        n_cmp++;
        if (det_ch !== 2'(k - 8)) begin n_bad++; $display("FAIL rr_det_ch cycle%0d got %0d want %0d", k, det_ch, k - 8); end
      end
    end
    drive(4'b0, 4'b0, 4'b0);
    for (int i = 0; i < 4; i++) begin
      rd_ch = 2'(i);
      #1;
      n_cmp++;
      if (rd_cnt !== 2'd1) begin n_bad++; $display("FAIL rr_cnt ch%0d got %0d want 1", i, rd_cnt); end
    end
  endtask

  task automatic test_rr_pair();
    logic [3:0] exp_rdy;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      drive(4'b0011, 4'b0000, 4'b0);
      exp_rdy = (k % 2 == 0) ? 4'b0001 : 4'b0010;
      #1;
      n_cmp++;
      if (ch_ready !== exp_rdy) begin n_bad++; $display("FAIL rr_pair_grant cycle%0d got %b want %b", k, ch_ready, exp_rdy); end
      step();
    end
    drive(4'b0, 4'b0, 4'b0);
  endtask

  task automatic test_prio();
    logic [2:0] seq;
    seq = 3'b101;
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      drive(4'b0011, {2'b00, 1'b1, seq[2 - (k % 3)]}, 4'b0);
      #1;
      n_cmp++;
      if (ch_ready !== 4'b0001) begin n_bad++; $display("FAIL prio_grant cycle%0d got %b want 0001", k, ch_ready); end
      step();
      if (k == 2) begin
        n_cmp++;
        if (det_valid !== 1'b1 || det_ch !== 2'd0) begin
          n_bad++; $display("FAIL prio_det got v=%b ch=%0d want v=1 ch=0", det_valid, det_ch);
        end
      end
    end
    drive(4'b0, 4'b0, 4'b0);
  endtask

  task automatic test_interleave();
    apply_reset();
    drive(4'b0010, 4'b0010, 4'b0);
    step();
    drive(4'b0010, 4'b0000, 4'b0);
    step();
    for (int k = 0; k < 6; k++) begin
      drive(4'b0100, 4'b0000, 4'b0);
      step();
      n_cmp++;
      if (det_valid !== 1'b0) begin n_bad++; $display("FAIL inter_ch2_det bit%0d got %b want 0", k, det_valid); end
    end
    drive(4'b0010, 4'b0010, 4'b0);
    step();
    n_cmp++;
    if (det_valid !== 1'b1 || det_ch !== 2'd1) begin
      n_bad++; $display("FAIL inter_ch1_det got v=%b ch=%0d want v=1 ch=1", det_valid, det_ch);
    end
    drive(4'b0, 4'b0, 4'b0);
    step();
    n_cmp++;
    if (det_valid !== 1'b0) begin n_bad++; $display("FAIL inter_pulse_len got %b want 0", det_valid); end
    rd_ch = 2'd2;
    #1;
    n_cmp++;
    if (rd_cnt !== 2'd0) begin n_bad++; $display("FAIL inter_cnt2 got %0d want 0", rd_cnt); end
    rd_ch = 2'd1;
    #1;
    n_cmp++;
    if (rd_cnt !== 2'd1) begin n_bad++; $display("FAIL inter_cnt1 got %0d want 1", rd_cnt); end
  endtask

  task automatic test_saturation();
    logic [10:0] seq;
    logic        exp_det;
    int          exp_cnt;
    seq     = 11'b10101010101;
    exp_cnt = 0;
    apply_reset();
    rd_ch = 2'd0;
    for (int k = 0; k < 11; k++) begin
      drive(4'b0001, {3'b000, seq[10-k]}, 4'b0);
      step();
      exp_det = (k >= 2) && (k % 2 == 0);
      if (exp_det && exp_cnt < 3) exp_cnt++;
      n_cmp++;
      if (det_valid !== exp_det) begin n_bad++; $display("FAIL sat_det bit%0d got %b want %b", k, det_valid, exp_det); end
      n_cmp++;
      if (rd_cnt !== 2'(exp_cnt)) begin n_bad++; $display("FAIL sat_cnt bit%0d got %0d want %0d", k, rd_cnt, exp_cnt); end
    end
    drive(4'b0, 4'b0, 4'b0);
  endtask

  task automatic test_clear();
    logic [2:0] seq;
    seq = 3'b101;
    apply_reset();
    rd_ch = 2'd0;
    for (int k = 0; k < 3; k++) begin
      drive(4'b0001, {3'b000, seq[2-k]}, 4'b0);
      step();
    end
    n_cmp++;
    if (det_valid !== 1'b1) begin n_bad++; $display("FAIL clr_pre_det got %b want 1", det_valid); end
    drive(4'b0001, 4'b0000, 4'b0);
    step();
    drive(4'b0001, 4'b0001, 4'b0001);
    #1;
    n_cmp++;
    if (ch_ready !== 4'b0001) begin n_bad++; $display("FAIL clr_ready got %b want 0001", ch_ready); end
    step();
    n_cmp++;
    if (det_valid !== 1'b0) begin n_bad++; $display("FAIL clr_det got %b want 0", det_valid); end
    n_cmp++;
    if (rd_cnt !== 2'd0) begin n_bad++; $display("FAIL clr_cnt got %0d want 0", rd_cnt); end
    for (int k = 0; k < 3; k++) begin
      drive(4'b0001, {3'b000, seq[2-k]}, (k == 2) ? 4'b0010 : 4'b0000);
      step();
      n_cmp++;
      if (det_valid !== (k == 2)) begin n_bad++; $display("FAIL clr_after_det bit%0d got %b want %b", k, det_valid, (k == 2)); end
    end
    drive(4'b0, 4'b0, 4'b0);
    #1;
    n_cmp++;
    if (rd_cnt !== 2'd1) begin n_bad++; $display("FAIL clr_after_cnt got %0d want 1", rd_cnt); end
  endtask

  task automatic test_async_reset();
    logic [2:0] seq;
    seq = 3'b101;
    apply_reset();
    rd_ch = 2'd0;
    for (int k = 0; k < 3; k++) begin
      drive(4'b0001, {3'b000, seq[2-k]}, 4'b0);
      step();
    end
    drive(4'b0, 4'b0, 4'b0);
    n_cmp++;
    if (det_valid !== 1'b1) begin n_bad++; $display("FAIL arst_pre_det got %b want 1", det_valid); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (det_valid !== 1'b0) begin n_bad++; $display("FAIL arst_det_immediate got %b want 0", det_valid); end
    n_cmp++;
    if (rd_cnt !== 2'd0) begin n_bad++; $display("FAIL arst_cnt_immediate got %0d want 0", rd_cnt); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(4'b0001, 4'b0000, 4'b0);
    step();
    n_cmp++;
    if (det_valid !== 1'b0) begin n_bad++; $display("FAIL arst_post_bit0 got %b want 0", det_valid); end
    drive(4'b0001, 4'b0001, 4'b0);
    step();
    n_cmp++;
    if (det_valid !== 1'b0) begin n_bad++; $display("FAIL arst_post_bit1 got %b want 0", det_valid); end
    drive(4'b0, 4'b0, 4'b0);
  endtask

  initial begin
    reset = 1'b1;
    rd_ch = 2'd0;
    drive(4'b0, 4'b0, 4'b0);
    test_reset();
    test_single();
`ifdef SEQ_DETECT_SCHED_PRIO_EN
    test_prio();
`else
    test_round_robin();
    test_rr_pair();
`endif
    test_interleave();
    test_saturation();
    test_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
